// File: rtl/dram_read_dma.sv
// dram_read_dma
// Read-side DMA engine. Takes one (base address, word count) command, issues
// single-word Avalon-style DRAM reads (honouring DRAM_WaitRequest) and streams
// the returned words out of a small show-ahead FIFO on a valid/ready port.
//
// Optional feature macro: DMA_ALIGN_CHECK_EN
//   defined   : a command with cmd_addr[1:0] != 0 is consumed without reads,
//               and err/done pulse together on the next cycle.
//   undefined : cmd_addr[1:0] is forced to 0 on latch and err is tied 0.
//
// Ports:
//   clock, reset          sole clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready while idle)
//   cmd_addr, cmd_len     first word byte address, number of 32-bit words
//   DRAM_*                Avalon-style master read port
//   out_valid/out_ready   output stream handshake
//   out_data, out_last    FIFO head word, head is final word of the command
//   busy                  command in progress
//   done                  one-cycle completion pulse
//   err                   one-cycle misalignment pulse (check build only)
module dram_read_dma #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             DRAM_WaitRequest,
  output logic             DRAM_Read,
  output logic [31:0]      DRAM_Address,
  output logic [3:0]       DRAM_ByteEnable,
  input  logic [31:0]      DRAM_ReadData,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t           state;
  logic [31:0]      rd_addr;
  logic [LEN_W-1:0] remaining;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [31:0]           data_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] last_bits;

  logic push;
  logic pop;

  // Reads are only requested while words remain and the FIFO has room, so a
  // completed read can always be stored without a skid buffer.
  assign DRAM_Read       = (state == READ) && (remaining != '0) && (count != FULL);
  assign DRAM_Address    = rd_addr;
  assign DRAM_ByteEnable = 4'hF;

  assign push = DRAM_Read && !DRAM_WaitRequest;
  assign pop  = out_valid && out_ready;

  // Head outputs are gated by occupancy so stale entries never leak out.
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? data_mem[rd_ptr] : 32'h0;
  assign out_last  = out_valid && last_bits[rd_ptr];
  assign busy      = (state != IDLE);

  // FIFO storage carries no reset; occupancy gating makes its contents moot.
  always_ff @(posedge clock) begin
    if (push) begin
      data_mem[wr_ptr]  <= DRAM_ReadData;
      last_bits[wr_ptr] <= (remaining == LEN_W'(1));
    end
  end

`ifdef DMA_ALIGN_CHECK_EN
  logic err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Control FSM, address/length counters and FIFO pointers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rd_addr   <= 32'h0;
      remaining <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      done      <= 1'b0;
`ifdef DMA_ALIGN_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef DMA_ALIGN_CHECK_EN
      err_q <= 1'b0;
`endif
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid) begin
            rd_addr <= cmd_addr & 32'hFFFF_FFFC;
`ifdef DMA_ALIGN_CHECK_EN
            if (cmd_addr[1:0] != 2'b00) begin
              err_q <= 1'b1;
              done  <= 1'b1;
            end else
`endif
            if (cmd_len == '0) begin
              done <= 1'b1;
            end else begin
              remaining <= cmd_len;
              state     <= READ;
              cmd_ready <= 1'b0;
            end
          end
        end
        READ: begin
          if (push) begin
            rd_addr   <= rd_addr + 32'd4;
            remaining <= remaining - 1'b1;
            if (remaining == LEN_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && out_last) begin
            done      <= 1'b1;
            state     <= IDLE;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_read_dma.sv
// tb_dram_read_dma
// Directed self-checking bench for dram_read_dma. A small DRAM model returns a
// word derived from the address; a negedge monitor logs read completions,
// stream pops and done/err pulses, which are compared to hand-derived values.
module tb_dram_read_dma;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        DRAM_WaitRequest;
  logic        DRAM_Read;
  logic [31:0] DRAM_Address;
  logic [3:0]  DRAM_ByteEnable;
  logic [31:0] DRAM_ReadData;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        err;

  int tests_run = 0;
  int tests_failed = 0;

  dram_read_dma #(.FIFO_DEPTH(4), .LEN_W(16)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .DRAM_WaitRequest(DRAM_WaitRequest), .DRAM_Read(DRAM_Read),
    .DRAM_Address(DRAM_Address), .DRAM_ByteEnable(DRAM_ByteEnable),
    .DRAM_ReadData(DRAM_ReadData),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // DRAM model: data follows the address, optional 3-cycle stall per word.
  logic stall_mode;
  int   stall_cnt;
  assign DRAM_ReadData    = DRAM_Read ? mem_word(DRAM_Address) : 32'h0;
  assign DRAM_WaitRequest = stall_mode && (stall_cnt < 3);

  always @(posedge clock) begin
    if (!reset) stall_cnt <= 0;
    else if (DRAM_Read && !DRAM_WaitRequest) stall_cnt <= 0;
    else if (DRAM_Read) stall_cnt <= stall_cnt + 1;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor log
  logic [31:0] rd_addrs[$];
  logic [32:0] pops[$];
  int read_cycles, done_cnt, err_cnt, hold_bad;
  int acc_cyc, done_cyc, first_rd_cyc, last_push_cyc, first_vld_cyc, err_cyc;
  logic done_ready;
  logic prev_stall;
  logic [31:0] prev_addr;

  always @(negedge clock) begin
    if (cmd_valid && cmd_ready) acc_cyc = cyc;
    if (DRAM_Read) begin
      read_cycles++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
    end
    if (prev_stall && (!DRAM_Read || DRAM_Address != prev_addr)) hold_bad++;
    prev_stall = DRAM_Read && DRAM_WaitRequest;
    prev_addr  = DRAM_Address;
    if (DRAM_Read && !DRAM_WaitRequest) begin
      rd_addrs.push_back(DRAM_Address);
      last_push_cyc = cyc;
    end
    if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (out_valid && out_ready) pops.push_back({out_last, out_data});
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_ready = cmd_ready;
    end
    if (err) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic clearLog();
    rd_addrs.delete();
    pops.delete();
    read_cycles = 0; done_cnt = 0; err_cnt = 0; hold_bad = 0;
    acc_cyc = -1; done_cyc = -1; first_rd_cyc = -1; last_push_cyc = -1;
    first_vld_cyc = -1; err_cyc = -1; done_ready = 1'b0;
    prev_stall = 1'b0; prev_addr = 32'h0;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [15:0] len);
    clearLog();
    @(posedge clock); #1;
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = len;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic waitDone(input int max_cycles);
    int n = 0;
    while (done_cnt == 0 && n < max_cycles) begin
      @(negedge clock);
      n++;
    end
    checkOutput("done_seen", 64'(done_cnt != 0), 64'd1);
  endtask

  // Checks an in-order stream of n words starting at base, last only on final.
  task automatic checkStream(input string tag, input logic [31:0] base, input int n);
    checkOutput({tag, "_pop_count"}, 64'(pops.size()), 64'(n));
    for (int i = 0; i < n && i < pops.size(); i++) begin
      checkOutput({tag, "_data"}, 64'(pops[i][31:0]), 64'(mem_word(base + 32'(4 * i))));
      checkOutput({tag, "_last"}, 64'(pops[i][32]), 64'(i == n - 1));
    end
  endtask

  initial begin
    reset = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr = 32'h0;
    cmd_len = 16'h0;
    out_ready = 1'b1;
    stall_mode = 1'b0;
    clearLog();

    // Reset values
    repeat (2) @(negedge clock);
    checkOutput("rst_DRAM_Read", 64'(DRAM_Read), 64'd0);
    checkOutput("rst_DRAM_Address", 64'(DRAM_Address), 64'h0);
    checkOutput("rst_ByteEnable", 64'(DRAM_ByteEnable), 64'hF);
    checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_last", 64'(out_last), 64'd0);
    checkOutput("rst_out_data", 64'(out_data), 64'h0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);
    #2 reset = 1'b1;
    @(negedge clock);
    checkOutput("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);

    // Normal 5-word transfer
    applyStimulus(32'h1000, 16'd5);
    waitDone(50);
    checkOutput("norm_read_count", 64'(rd_addrs.size()), 64'd5);
    for (int i = 0; i < rd_addrs.size(); i++)
      checkOutput("norm_addr", 64'(rd_addrs[i]), 64'(32'h1000 + 32'(4 * i)));
    checkOutput("norm_first_read", 64'(first_rd_cyc - acc_cyc), 64'd1);
    checkOutput("norm_last_read", 64'(last_push_cyc - acc_cyc), 64'd5);
    checkOutput("norm_first_valid", 64'(first_vld_cyc - acc_cyc), 64'd2);
    checkOutput("norm_done_lat", 64'(done_cyc - acc_cyc), 64'd7);
    checkOutput("norm_done_ready", 64'(done_ready), 64'd1);
    checkStream("norm", 32'h1000, 5);
    @(negedge clock);
    checkOutput("norm_busy_after", 64'(busy), 64'd0);

    // Stalls: 3 wait cycles on every word
    stall_mode = 1'b1;
    applyStimulus(32'h2000, 16'd3);
    waitDone(80);
    stall_mode = 1'b0;
    checkOutput("stall_push_count", 64'(rd_addrs.size()), 64'd3);
    checkOutput("stall_read_cycles", 64'(read_cycles), 64'd12);
    checkOutput("stall_addr_hold", 64'(hold_bad), 64'd0);
    checkOutput("stall_done_lat", 64'(done_cyc - acc_cyc), 64'd14);
    checkStream("stall", 32'h2000, 3);

    // Backpressure with a 4-entry FIFO
    out_ready = 1'b0;
    applyStimulus(32'h3000, 16'd10);
    repeat (10) @(negedge clock);
    checkOutput("bp_reads_full", 64'(rd_addrs.size()), 64'd4);
    checkOutput("bp_read_low", 64'(DRAM_Read), 64'd0);
    checkOutput("bp_busy", 64'(busy), 64'd1);
    checkOutput("bp_head", 64'(out_data), 64'(mem_word(32'h3000)));
    @(posedge clock); #1 out_ready = 1'b1;
    @(posedge clock); #1 out_ready = 1'b0;
    repeat (6) @(negedge clock);
    checkOutput("bp_one_more", 64'(rd_addrs.size()), 64'd5);
    checkOutput("bp_one_pop", 64'(pops.size()), 64'd1);
    @(posedge clock); #1 out_ready = 1'b1;
    waitDone(80);
    checkStream("bp", 32'h3000, 10);

    // Zero length
    applyStimulus(32'h4000, 16'd0);
    waitDone(10);
    checkOutput("zero_reads", 64'(read_cycles), 64'd0);
    checkOutput("zero_done_lat", 64'(done_cyc - acc_cyc), 64'd1);
    checkOutput("zero_ready", 64'(done_ready), 64'd1);

    // Misaligned address
    applyStimulus(32'h1002, 16'd2);
    waitDone(30);
`ifdef DMA_ALIGN_CHECK_EN
    checkOutput("align_err_cnt", 64'(err_cnt), 64'd1);
    checkOutput("align_err_lat", 64'(err_cyc - acc_cyc), 64'd1);
    checkOutput("align_done_lat", 64'(done_cyc - acc_cyc), 64'd1);
    checkOutput("align_reads", 64'(read_cycles), 64'd0);
`else
    checkOutput("align_err_cnt", 64'(err_cnt), 64'd0);
    checkOutput("align_read_count", 64'(rd_addrs.size()), 64'd2);
    if (rd_addrs.size() > 0)
      checkOutput("align_first_addr", 64'(rd_addrs[0]), 64'h1000);
    checkStream("align", 32'h1000, 2);
`endif

    // Reset mid-READ at word 2 of 8
    applyStimulus(32'h5000, 16'd8);
    begin
      int n = 0;
      while (rd_addrs.size() < 2 && n < 20) begin
        @(negedge clock);
        #2;
        n++;
      end
    end
    checkOutput("mid_reached_word2", 64'(rd_addrs.size() >= 2), 64'd1);
    reset = 1'b0;
    #1;
    checkOutput("mid_DRAM_Read", 64'(DRAM_Read), 64'd0);
    checkOutput("mid_out_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_busy", 64'(busy), 64'd0);
    done_cnt = 0;
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    repeat (12) @(negedge clock);
    checkOutput("mid_no_done", 64'(done_cnt), 64'd0);
    checkOutput("mid_idle_ready", 64'(cmd_ready), 64'd1);
    checkOutput("mid_no_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_addr_zero", 64'(DRAM_Address), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dram_read_dma.md
# dram_read_dma

Read-side DMA engine between the accelerator's load sequencing and the Avalon-style DRAM controller master port. It accepts a (base address, word count) command, issues single-word DRAM reads while honouring `WaitRequest`, and buffers returned words in a small show-ahead FIFO. The FIFO feeds a valid/ready stream to the consumer: the weight, input or bias SRAM fill path. It replaces ad-hoc per-word DRAM polling with one command per contiguous region.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: read-data FIFO entries; power of two, ≥2.
- `LEN_W`, 16: width of the word-count field.

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  engine idle, can take a command.
- `cmd_addr`  in  32  DRAM byte address of the first word.
- `cmd_len`  in  LEN_W  number of 32-bit words.
- `DRAM_WaitRequest`  in  1  controller stall.
- `DRAM_Read`  out  1  read request.
- `DRAM_Address`  out  32  byte address of the current read.
- `DRAM_ByteEnable`  out  4  constant 4'hF.
- `DRAM_ReadData`  in  32  valid in any cycle with `DRAM_Read`=1 and `DRAM_WaitRequest`=0.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer accepts.
- `out_data`  out  32  FIFO head word.
- `out_last`  out  1  head is the final word of the command.
- `busy`  out  1  command in progress.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle misalignment pulse; constant 0 when `DMA_ALIGN_CHECK_EN` is undefined.

## Operation
- States: IDLE, READ, DRAIN.
- IDLE:
  - `cmd_ready`=1.
  - When `cmd_valid`, the engine latches the address into `rd_addr` and `cmd_len` into `remaining` and `total`.
  - If `cmd_len`=0, no reads are issued, `done` pulses next cycle, and the state stays IDLE.
  - Otherwise the state goes to READ.
- READ:
  - `DRAM_Read` = (`remaining`≠0) && (`count`≠`FIFO_DEPTH`). This is combinational from registered state.
  - A read completes when `DRAM_Read` && !`DRAM_WaitRequest`. On completion: `DRAM_ReadData` is pushed, `rd_addr` += 4, `remaining` −1.
  - When `remaining` reaches 0, the state goes to DRAIN.
- DRAIN: `DRAM_Read`=0. The engine waits for the last-word handshake (`out_valid` && `out_ready` && `out_last`), pulses `done` next cycle, and returns to IDLE.
- FIFO:
  - Show-ahead: `out_data` is the head word. `out_valid` = (`count`≠0).
  - A push and a pop in the same cycle leave `count` unchanged. Pointers wrap modulo `FIFO_DEPTH`.
  - `out_last` = head is word index `total`−1. A per-entry last bit is set on the push that takes `remaining` from 1 to 0.
- `busy` = state≠IDLE.
- Address arithmetic: 32-bit, wraps silently at 2^32.
- Reset, including mid-operation:
  - State goes to IDLE. FIFO is emptied, counters are cleared, and an outstanding read is abandoned.
  - Reset values: `DRAM_Read`=0, `DRAM_Address`=0, `DRAM_ByteEnable`=4'hF, `cmd_ready`=1 one cycle after reset release (0 while reset asserted), `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0, `done`=0, `err`=0.

## Timing
- Command accept is cycle T. `DRAM_Read` rises in T+1.
- With zero wait states, words complete one per cycle. The first word is visible on `out_valid` in T+2.
- While `DRAM_WaitRequest`=1, `DRAM_Read` and `DRAM_Address` hold stable.
- FIFO full: `DRAM_Read` drops in the same cycle `count` reaches `FIFO_DEPTH`. It re-asserts in the cycle after a pop.
- Last-word handshake is cycle L. `done` pulses in L+1. `cmd_ready` returns in L+1.
- A new command is accepted no earlier than L+1.
- Minimum latency for an N-word command with no stalls and `out_ready`=1: `done` at T+N+2.

## Configuration
- `DMA_ALIGN_CHECK_EN` defined:
  - A command with `cmd_addr[1:0]`≠0 is accepted and consumed, but no reads are issued.
  - `err` and `done` pulse together in the next cycle, and the state stays IDLE.
- Undefined: `cmd_addr[1:0]` is forced to 0 on latch and `err` is tied 0.

## Test plan
- Reset values: check every output. Also assert reset mid-READ at word 2 of 8 → `DRAM_Read`=0 immediately, `out_valid`=0, `busy`=0, and no `done`.
- Normal transfer: cmd_addr=0x1000, cmd_len=5, no stalls, `out_ready`=1 → reads to 0x1000..0x1010 in 5 consecutive cycles. Data stream D0..D4 is in order, `out_last` only on D4, `done` at T+7.
- Stalls: `DRAM_WaitRequest` high 3 cycles on each word of a 3-word command → address is held stable during every stall and exactly 3 words are pushed.
- Backpressure: `out_ready`=0 with cmd_len=10 and `FIFO_DEPTH`=4 → `DRAM_Read` drops after 4 words. Releasing `out_ready` for 1 cycle gives exactly 1 more read. All 10 words arrive in order.
- Zero length: cmd_len=0 → no `DRAM_Read`, `done` in T+1, `cmd_ready` high in T+1.
- Alignment: with `DMA_ALIGN_CHECK_EN`, cmd_addr=0x1002 gives `err`=`done`=1 at T+1 and no reads. Without it, the first read goes to 0x1000.
